noc_mux2_reg: RTL and testbench

- Two-input flit multiplexer for the NoC router crossbar.
- One-hot `sel` picks one of two input ports (data, valid, virtual-channel ID); the choice is driven to a single output port through an output register.
- Used standalone for per-port energy characterization; a wide one-hot select matches the router's port-grant vector.

---
 rtl/noc_pkg.sv | 16 +
 rtl/noc_mux2_reg_if.sv | 14 +
 rtl/noc_mux2_sel.sv | 22 ++
 rtl/noc_mux2_reg.sv | 69 ++++++
 tb/tb_noc_mux2_reg.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants: default widths, flit type encodings and enable levels.
package noc_pkg;

  localparam int unsigned NOC_DATA_W = 66;
  localparam int unsigned NOC_VCH_W  = 1;
  localparam int unsigned NOC_SEL_W  = 5;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage : noc_pkg

// File: rtl/noc_mux2_reg_if.sv
// One flit port (data, valid, virtual channel); master drives, slave receives.
interface noc_mux2_reg_if #(
  parameter int unsigned DATA_W = noc_pkg::NOC_DATA_W,
  parameter int unsigned VCH_W  = noc_pkg::NOC_VCH_W
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic [VCH_W-1:0]  vch;

  modport master (output data, output valid, output vch);
  modport slave  (input  data, input  valid, input  vch);

endinterface : noc_mux2_reg_if

// File: rtl/noc_mux2_sel.sv
// One-hot grant to fixed-priority port decode; the lower index wins, bits above 1 ignored.
module noc_mux2_sel #(
  parameter int unsigned SEL_W = noc_pkg::NOC_SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic             gnt0_c,
  output logic             gnt1_c,
  output logic             none_c
);

  assign gnt0_c = sel_i[0];
  assign gnt1_c = ~sel_i[0] & sel_i[1];
  assign none_c = ~(sel_i[0] | sel_i[1]);

  generate
    if (SEL_W > 2) begin : g_hi
      logic unused_sel_hi;
      assign unused_sel_hi = ^sel_i[SEL_W-1:2];
    end
  endgenerate

endmodule : noc_mux2_sel

// File: rtl/noc_mux2_reg.sv
// Two-input registered flit mux for the router crossbar.
// MUX_HOLD_EN: idle cycles keep odata/ovch and only drop valid.
module noc_mux2_reg
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W = NOC_DATA_W,
  parameter int unsigned VCH_W  = NOC_VCH_W,
  parameter int unsigned SEL_W  = NOC_SEL_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [SEL_W-1:0] sel,
  noc_mux2_reg_if.slave    in0_i,
  noc_mux2_reg_if.slave    in1_i,
  noc_mux2_reg_if.master   out_o
);

  logic gnt0_c, gnt1_c, none_c;

  logic [DATA_W-1:0] data_q, data_d;
  logic [VCH_W-1:0]  vch_q,  vch_d;
  logic              valid_q, valid_d;

  noc_mux2_sel #(.SEL_W(SEL_W)) u_sel (
    .sel_i  (sel),
    .gnt0_c (gnt0_c),
    .gnt1_c (gnt1_c),
    .none_c (none_c)
  );

  // Only a granted, valid port loads the data path; otherwise it idles.
  always_comb begin
    data_d  = '0;
    vch_d   = '0;
    valid_d = DISABLE;
`ifdef MUX_HOLD_EN
    data_d  = data_q;
    vch_d   = vch_q;
`endif
    if (!none_c) begin
      if (gnt0_c && in0_i.valid) begin
        data_d  = in0_i.data;
        vch_d   = in0_i.vch;
        valid_d = ENABLE;
      end else if (gnt1_c && in1_i.valid) begin
        data_d  = in1_i.data;
        vch_d   = in1_i.vch;
        valid_d = ENABLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_q  <= '0;
      vch_q   <= '0;
      valid_q <= DISABLE;
    end else begin
      data_q  <= data_d;
      vch_q   <= vch_d;
      valid_q <= valid_d;
    end
  end

  assign out_o.data  = data_q;
  assign out_o.vch   = vch_q;
  assign out_o.valid = valid_q;

endmodule : noc_mux2_reg

// File: tb/tb_noc_mux2_reg.sv
// Directed bench for noc_mux2_reg; expectations adapt to MUX_HOLD_EN.
module tb_noc_mux2_reg;
  import noc_pkg::*;

  localparam int unsigned DW = NOC_DATA_W;
  localparam int unsigned VW = NOC_VCH_W;
  localparam int unsigned SW = NOC_SEL_W;

  logic          clk = 1'b0;
  logic          rst_;
  logic [SW-1:0] sel;

  noc_mux2_reg_if #(.DATA_W(DW), .VCH_W(VW)) in0 ();
  noc_mux2_reg_if #(.DATA_W(DW), .VCH_W(VW)) in1 ();
  noc_mux2_reg_if #(.DATA_W(DW), .VCH_W(VW)) out ();

  noc_mux2_reg #(.DATA_W(DW), .VCH_W(VW), .SEL_W(SW)) dut (
    .clk   (clk),
    .rst_  (rst_),
    .sel   (sel),
    .in0_i (in0),
    .in1_i (in1),
    .out_o (out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [DW-1:0] e_data,
                           input logic e_valid, input logic [VW-1:0] e_vch);
    check({tag, ".data"},  out.data, e_data);
    check({tag, ".valid"}, DW'(out.valid), DW'(e_valid));
    check({tag, ".vch"},   DW'(out.vch), DW'(e_vch));
  endtask

  logic [DW-1:0] flit, last, idle_d;
  logic [VW-1:0] idle_v;

  initial begin
    rst_ = 1'b0;
    sel = 5'b00010;
    in0.data = '0; in0.valid = 1'b0; in0.vch = '0;
    in1.data = {TYPE_HEAD, 32'h0, 32'h11}; in1.valid = 1'b1; in1.vch = 1'b1;

    // 1: held in reset, then first flit after release
    tick(); tick();
    check_out("rst_hold", '0, 1'b0, 1'b0);
    rst_ = 1'b1;
    tick();
    check_out("rst_release", {TYPE_HEAD, 32'h0, 32'h11}, 1'b1, 1'b1);

    // 2: port 1 packet, head + 20 data + tail
    in1.vch = 1'b0;
    in1.data = {TYPE_HEAD, 32'h0, 32'h4};
    tick();
    check_out("p1_head", {TYPE_HEAD, 32'h0, 32'h4}, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      flit = {TYPE_DATA, (i % 2 == 0) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA};
      in1.data = flit;
      tick();
      check_out($sformatf("p1_data%0d", i), flit, 1'b1, 1'b0);
    end
    in1.data = {TYPE_TAIL, 32'hCAFE, 32'hF00D};
    tick();
    check_out("p1_tail", {TYPE_TAIL, 32'hCAFE, 32'hF00D}, 1'b1, 1'b0);
    last = {TYPE_TAIL, 32'hCAFE, 32'hF00D};
    in1.valid = 1'b0;
    tick();
`ifdef MUX_HOLD_EN
    idle_d = last;
`else
    idle_d = '0;
`endif
    check_out("p1_after", idle_d, 1'b0, 1'b0);

    // 3: port 0 select with both valid
    sel = 5'b00001;
    in0.data = {TYPE_HEAD, 32'h0, 32'h9}; in0.valid = 1'b1; in0.vch = 1'b1;
    in1.data = {TYPE_DATA, 64'h1234}; in1.valid = 1'b1; in1.vch = 1'b0;
    tick();
    check_out("p0_sel", {TYPE_HEAD, 32'h0, 32'h9}, 1'b1, 1'b1);

    // 4: priority and no-grant
    sel = 5'b00011;
    in0.data = {TYPE_DATA, 64'h0BAD_F00D_0000_0001};
    tick();
    check_out("prio", {TYPE_DATA, 64'h0BAD_F00D_0000_0001}, 1'b1, 1'b1);
    sel = 5'b00010;
    tick();
    check_out("p1_sel", {TYPE_DATA, 64'h1234}, 1'b1, 1'b0);
    sel = 5'b00011;
    tick();
    check_out("prio2", {TYPE_DATA, 64'h0BAD_F00D_0000_0001}, 1'b1, 1'b1);
    sel = 5'b11100;
    tick();
`ifdef MUX_HOLD_EN
    idle_d = {TYPE_DATA, 64'h0BAD_F00D_0000_0001}; idle_v = 1'b1;
`else
    idle_d = '0; idle_v = 1'b0;
`endif
    check_out("no_grant", idle_d, 1'b0, idle_v);

    // 5: forward a flit then drop valid
    sel = 5'b00001;
    in0.data = 66'h1_DEADBEEF_01234567; in0.vch = 1'b1;
    tick();
    check_out("fwd", 66'h1_DEADBEEF_01234567, 1'b1, 1'b1);
    in0.valid = 1'b0;
    tick();
`ifdef MUX_HOLD_EN
    idle_d = 66'h1_DEADBEEF_01234567; idle_v = 1'b1;
`else
    idle_d = '0; idle_v = 1'b0;
`endif
    check_out("drop_valid", idle_d, 1'b0, idle_v);

    // 6: async reset mid-packet, between edges
    sel = 5'b00010;
    in1.data = {TYPE_DATA, 64'h7777_0000_7777_0000}; in1.valid = 1'b1; in1.vch = 1'b1;
    tick();
    check_out("mid_pkt", {TYPE_DATA, 64'h7777_0000_7777_0000}, 1'b1, 1'b1);
    #2 rst_ = 1'b0;
    #1;
    check_out("async_rst", '0, 1'b0, 1'b0);
    tick();
    check_out("rst_low", '0, 1'b0, 1'b0);
    in1.data = {TYPE_TAIL, 64'h1};
    rst_ = 1'b1;
    tick();
    check_out("post_rst", {TYPE_TAIL, 64'h1}, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_noc_mux2_reg
